// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the set-associative cache blocks.
//   CACHE_WAYS / CACHE_SETS : default associativity and set count
//   PLRU_BITS               : tree pseudo-LRU bits per set (ways - 1)
//   set_idx_w()             : width of a set index for a given set count
//   plru_vec_t              : per-set PLRU vector for the default geometry
// -----------------------------------------------------------------------------
package cache_pkg;
    localparam int CACHE_WAYS = 4;
    localparam int CACHE_SETS = 64;
    localparam int PLRU_BITS  = CACHE_WAYS - 1;

    // Never returns zero so a degenerate one-set cache still gets a legal port.
    function automatic int set_idx_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    typedef logic [PLRU_BITS-1:0] plru_vec_t;
endpackage

// File: rtl/cache_plru_tree.sv
// -----------------------------------------------------------------------------
// cache_plru_tree
// Purely combinational tree pseudo-LRU evaluator for a single set.
//   plru_i      : the set's PLRU vector, heap order (node n -> children 2n+1, 2n+2)
//   valid_i     : per-way valid bits; any invalid way wins over the tree
//   access_oh_i : one-hot accessed way (all-zero means no access)
//   victim_oh_o : one-hot victim way
//   plru_next_o : vector after the access has been applied
// Node bit 0 points at the left (lower-index) subtree, 1 at the right one.
// -----------------------------------------------------------------------------
module cache_plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = CACHE_WAYS
) (
    input  logic [WAYS-2:0] plru_i,
    input  logic [WAYS-1:0] valid_i,
    input  logic [WAYS-1:0] access_oh_i,
    output logic [WAYS-1:0] victim_oh_o,
    output logic [WAYS-2:0] plru_next_o
);
    localparam int LVLS = $clog2(WAYS);

    logic [WAYS-1:0] tree_oh;
    logic [WAYS-1:0] inv_oh;

    genvar gi, gl, gk;

    // A leaf is the tree victim when every node on its root path points toward it.
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_leaf
            logic [LVLS-1:0] lvl_match;
            for (gl = 0; gl < LVLS; gl++) begin : g_lvl
                localparam int NODE = (1 << gl) - 1 + (gi >> (LVLS - gl));
                localparam bit DIR  = ((gi >> (LVLS - 1 - gl)) & 1) != 0;
                assign lvl_match[gl] = (plru_i[NODE] == DIR);
            end
            assign tree_oh[gi] = &lvl_match;
        end
    endgenerate

    // Each node covers a contiguous block of ways; an access in its left half
    // points it right and vice versa. Nodes not covering the access keep their bit.
    generate
        for (gl = 0; gl < LVLS; gl++) begin : g_node_lvl
            for (gk = 0; gk < (1 << gl); gk++) begin : g_node
                localparam int NODE = (1 << gl) - 1 + gk;
                localparam int HALF = WAYS >> (gl + 1);
                localparam int BASE = gk * (WAYS >> gl);
                logic left_hit;
                logic right_hit;
                assign left_hit  = |access_oh_i[BASE +: HALF];
                assign right_hit = |access_oh_i[BASE + HALF +: HALF];
                assign plru_next_o[NODE] = left_hit  ? 1'b1 :
                                           right_hit ? 1'b0 : plru_i[NODE];
            end
        end
    endgenerate

    // Lowest-index invalid way: scan downward so the lowest one overwrites last.
    always_comb begin
        inv_oh = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                inv_oh    = '0;
                inv_oh[w] = 1'b1;
            end
        end
    end

    assign victim_oh_o = (&valid_i) ? tree_oh : inv_oh;
endmodule

// File: rtl/cache_plru_repl.sv
// -----------------------------------------------------------------------------
// cache_plru_repl
// Per-set tree pseudo-LRU replacement unit with a registered one-hot victim.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   lookup_vld_i/set_i  : victim request and its set
//   lookup_valid_i      : valid bits of the requested set (same cycle)
//   access_vld_i/set_i  : hit or fill report and its set
//   access_way_oh_i     : one-hot accessed way (zero = ignored)
//   victim_vld_o        : one-cycle pulse, the cycle after lookup_vld_i
//   victim_oh_o         : one-hot victim, holds while victim_vld_o is low
// Optional feature: CACHE_PLRU_BYPASS_EN forwards a same-cycle, same-set access
// update into the lookup; without it the lookup sees the pre-update tree.
// -----------------------------------------------------------------------------
module cache_plru_repl
    import cache_pkg::*;
#(
    parameter int WAYS = CACHE_WAYS,
    parameter int SETS = CACHE_SETS
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        lookup_vld_i,
    input  logic [set_idx_w(SETS)-1:0]  lookup_set_i,
    input  logic [WAYS-1:0]             lookup_valid_i,
    input  logic                        access_vld_i,
    input  logic [set_idx_w(SETS)-1:0]  access_set_i,
    input  logic [WAYS-1:0]             access_way_oh_i,
    output logic                        victim_vld_o,
    output logic [WAYS-1:0]             victim_oh_o
);
    localparam int PB = WAYS - 1;

    logic [PB-1:0]   plru_reg [SETS];
    logic            victim_vld_reg;
    logic [WAYS-1:0] victim_oh_reg;

    logic [PB-1:0]   upd_cur;
    logic [PB-1:0]   upd_next;
    logic [PB-1:0]   lkp_vec;
    logic [WAYS-1:0] lkp_victim;
    logic [WAYS-1:0] upd_victim_unused;
    logic [PB-1:0]   lkp_next_unused;

    assign upd_cur = plru_reg[access_set_i];

`ifdef CACHE_PLRU_BYPASS_EN
    // A zero access mask leaves upd_next equal to the stored vector, so no
    // extra qualification is needed on the forward.
    assign lkp_vec = (access_vld_i && (access_set_i == lookup_set_i)) ?
                     upd_next : plru_reg[lookup_set_i];
`else
    assign lkp_vec = plru_reg[lookup_set_i];
`endif

    // Update path: only the next-vector output matters here.
    cache_plru_tree #(.WAYS(WAYS)) u_tree_upd (
        .plru_i      (upd_cur),
        .valid_i     ({WAYS{1'b1}}),
        .access_oh_i (access_way_oh_i),
        .victim_oh_o (upd_victim_unused),
        .plru_next_o (upd_next)
    );

    // Lookup path: only the victim output matters here.
    cache_plru_tree #(.WAYS(WAYS)) u_tree_lkp (
        .plru_i      (lkp_vec),
        .valid_i     (lookup_valid_i),
        .access_oh_i ({WAYS{1'b0}}),
        .victim_oh_o (lkp_victim),
        .plru_next_o (lkp_next_unused)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                plru_reg[s] <= '0;
            end
            victim_vld_reg <= 1'b0;
            victim_oh_reg  <= '0;
        end else begin
            if (access_vld_i && (access_way_oh_i != '0)) begin
                plru_reg[access_set_i] <= upd_next;
            end
            victim_vld_reg <= lookup_vld_i;
            if (lookup_vld_i) begin
                victim_oh_reg <= lkp_victim;
            end
        end
    end

    // A multi-hot access would corrupt several subtrees at once.
    always_ff @(posedge clk_i) begin
        if (!rst_i && access_vld_i) begin
            assert ($onehot0(access_way_oh_i));
        end
    end

    assign victim_vld_o = victim_vld_reg;
    assign victim_oh_o  = victim_oh_reg;
endmodule

// File: tb/tb_cache_plru_repl.sv
// -----------------------------------------------------------------------------
// tb_cache_plru_repl
// Directed scenarios followed by random lookups/accesses. Expected victims come
// from a heap-walk reference model and are queued; a negedge monitor pops and
// compares. Build with CACHE_PLRU_BYPASS_EN to check the forwarding variant.
// -----------------------------------------------------------------------------
module tb_cache_plru_repl;
    localparam int WAYS = 4;
    localparam int SETS = 64;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            lookup_vld_i = 1'b0;
    logic [5:0]      lookup_set_i = '0;
    logic [WAYS-1:0] lookup_valid_i = '1;
    logic            access_vld_i = 1'b0;
    logic [5:0]      access_set_i = '0;
    logic [WAYS-1:0] access_way_oh_i = '0;
    logic            victim_vld_o;
    logic [WAYS-1:0] victim_oh_o;

    int tests = 0;
    int fails = 0;

    cache_plru_repl #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .lookup_vld_i    (lookup_vld_i),
        .lookup_set_i    (lookup_set_i),
        .lookup_valid_i  (lookup_valid_i),
        .access_vld_i    (access_vld_i),
        .access_set_i    (access_set_i),
        .access_way_oh_i (access_way_oh_i),
        .victim_vld_o    (victim_vld_o),
        .victim_oh_o     (victim_oh_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit model_tree [SETS][WAYS-1];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++)
                model_tree[s][n] = 1'b0;
    endfunction

    function automatic int model_victim(input int s, input logic [WAYS-1:0] valid);
        int n;
        for (int w = 0; w < WAYS; w++)
            if (!valid[w]) return w;
        n = 0;
        while (n < WAYS - 1)
            n = 2 * n + 1 + int'(model_tree[s][n]);
        return n - (WAYS - 1);
    endfunction

    // Climb from the accessed leaf, pointing each ancestor at the other child.
    function automatic void model_access(input int s, input int w);
        int c;
        int p;
        c = w + WAYS - 1;
        while (c > 0) begin
            p = (c - 1) / 2;
            model_tree[s][p] = (c == 2 * p + 1);
            c = p;
        end
    endfunction

    function automatic int oh_to_idx(input logic [WAYS-1:0] oh);
        for (int w = 0; w < WAYS; w++)
            if (oh[w]) return w;
        return -1;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int              set;
        logic [WAYS-1:0] oh;
    } exp_t;

    exp_t            exp_q[$];
    logic [WAYS-1:0] held_oh = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            tests++;
            if (victim_vld_o !== 1'b0 || victim_oh_o !== '0) begin
                fails++;
                $display("[TB] FAIL reset_state: got vld=%b oh=%b, want vld=0 oh=0000",
                         victim_vld_o, victim_oh_o);
            end
            held_oh = '0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (victim_vld_o !== 1'b1 || victim_oh_o !== e.oh) begin
                fails++;
                $display("[TB] FAIL victim set=%0d: got vld=%b oh=%b, want vld=1 oh=%b",
                         e.set, victim_vld_o, victim_oh_o, e.oh);
            end else begin
                $display("[TB] lookup set=%0d victim=%b ok", e.set, victim_oh_o);
            end
            held_oh = e.oh;
        end else begin
            tests++;
            if (victim_vld_o !== 1'b0 || victim_oh_o !== held_oh) begin
                fails++;
                $display("[TB] FAIL idle_hold: got vld=%b oh=%b, want vld=0 oh=%b",
                         victim_vld_o, victim_oh_o, held_oh);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic lv, input int ls,
                         input logic [WAYS-1:0] lval, input logic av,
                         input int as, input logic [WAYS-1:0] aw);
        exp_t e;
        @(negedge clk);
        #1;
        rst_i           = r;
        lookup_vld_i    = lv;
        lookup_set_i    = 6'(ls);
        lookup_valid_i  = lval;
        access_vld_i    = av;
        access_set_i    = 6'(as);
        access_way_oh_i = aw;
        if (r) begin
            model_clear();
        end else begin
`ifdef CACHE_PLRU_BYPASS_EN
            if (av && aw != '0) model_access(as, oh_to_idx(aw));
`endif
            if (lv) begin
                e.set = ls;
                e.oh  = '0;
                e.oh[model_victim(ls, lval)] = 1'b1;
                exp_q.push_back(e);
            end
`ifndef CACHE_PLRU_BYPASS_EN
            if (av && aw != '0) model_access(as, oh_to_idx(aw));
`endif
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '1, 1'b0, 0, '0);
    endtask

    task automatic lookup(input int s, input logic [WAYS-1:0] v);
        drive(1'b0, 1'b1, s, v, 1'b0, 0, '0);
    endtask

    task automatic access(input int s, input logic [WAYS-1:0] w);
        drive(1'b0, 1'b0, 0, '1, 1'b1, s, w);
    endtask

    initial begin
        logic [WAYS-1:0] rv;
        logic [WAYS-1:0] rw;
        model_clear();
        drive(1'b1, 1'b0, 0, '1, 1'b0, 0, '0);
        drive(1'b1, 1'b0, 0, '1, 1'b0, 0, '0);
        idle();

        // Fresh reset: way 0 everywhere.
        lookup(5, 4'b1111);
        // Touch way 0 of set 5: victim moves to way 2.
        access(5, 4'b0001);
        lookup(5, 4'b1111);
        // Set 7 sequence, then isolation check on set 8.
        access(7, 4'b0001);
        access(7, 4'b0100);
        access(7, 4'b0010);
        lookup(7, 4'b1111);
        lookup(8, 4'b1111);
        // Invalid way overrides the tree; zero access mask leaves state alone.
        lookup(7, 4'b1011);
        access(7, 4'b0000);
        lookup(7, 4'b1111);
        idle();

        // Same-cycle same-set collision after reset, then a follow-up lookup.
        drive(1'b1, 1'b0, 0, '1, 1'b0, 0, '0);
        drive(1'b0, 1'b1, 3, 4'b1111, 1'b1, 3, 4'b0001);
        lookup(3, 4'b1111);
        // Collision on different sets stays independent.
        drive(1'b0, 1'b1, 4, 4'b1111, 1'b1, 9, 4'b1000);
        lookup(9, 4'b1111);

        // Reset together with a lookup drops the request and clears state.
        access(10, 4'b0010);
        access(11, 4'b1000);
        access(12, 4'b0100);
        drive(1'b1, 1'b1, 10, 4'b1111, 1'b0, 0, '0);
        lookup(10, 4'b1111);
        lookup(11, 4'b1111);
        lookup(12, 4'b1111);
        idle();

        // Random traffic over a few sets so collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(3) == 0) ? WAYS'($urandom) : 4'b1111;
            rw = '0;
            if ($urandom_range(7) != 0) rw[$urandom_range(WAYS - 1)] = 1'b1;
            drive(1'b0, 1'($urandom), int'($urandom_range(7)), rv,
                  1'($urandom), int'($urandom_range(7)), rw);
        end

        idle();
        idle();
        idle();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending victims, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_plru_repl.md
# cache_plru_repl

Per-set tree pseudo-LRU replacement unit for the set-associative cache. It tracks access recency for every set and produces a registered one-hot victim way. That victim drives the select of the one-hot way mux (oh_logic_mux) on the fill/evict path. Hits and fills are reported back so the tree stays current.

## Interface

Parameters:
- WAYS, 4, associativity; power of two, >= 2
- SETS, 64, number of sets; power of two, >= 2

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- lookup_vld_i  input  1  victim request this cycle
- lookup_set_i  input  $clog2(SETS)  set index of request
- lookup_valid_i  input  WAYS  per-way valid bits of the requested set, same cycle as request
- access_vld_i  input  1  hit or fill occurred
- access_set_i  input  $clog2(SETS)  set index of access
- access_way_oh_i  input  WAYS  one-hot way accessed
- victim_vld_o  output  1  victim result valid (one-cycle pulse)
- victim_oh_o  output  WAYS  one-hot victim way

## Operation

- State: WAYS-1 bits per set, held in a flop array.
  - Heap indexing: node 0 is the root; node n has children 2n+1 and 2n+2.
  - Bit value 0 means the victim is in the left (lower-index) subtree; 1 means the right subtree.
- Victim selection:
  - If any bit of lookup_valid_i is 0, the victim is the lowest-index invalid way.
  - Otherwise, walk the tree from the root following the node bits to a leaf.
- Update on access_vld_i: every node on the path to the accessed way is set to point away from it.
  - Accessed way in the left subtree of a node: node bit = 1.
  - Accessed way in the right subtree: node bit = 0.
  - Nodes off the path are unchanged.
- Lookups do not modify state. Only accesses update the tree.
- access_way_oh_i == 0 with access_vld_i: no update.
- Multi-hot access_way_oh_i: behaviour undefined. A simulation assertion fires.
- Lookup and access in the same cycle to different sets: independent.

## Timing

- Reset values:
  - all PLRU bits 0, so every set's victim is way 0
  - victim_vld_o = 0
  - victim_oh_o = 0
- Lookup latency is 1 cycle: victim_vld_o/victim_oh_o are registered in the cycle after lookup_vld_i. A back-to-back lookup is accepted every cycle.
- victim_oh_o holds its last value while victim_vld_o = 0.
- Access latency: the state update is visible to lookups from the next cycle.
- Same-cycle lookup and access to the same set: see Configuration.
- Reset with lookup_vld_i high: the request is dropped. The next cycle shows victim_vld_o = 0 and all state cleared.
- No backpressure: the consumer must take the victim in the cycle victim_vld_o is high.

## Configuration

- CACHE_PLRU_BYPASS_EN defined: on a same-set collision, the lookup sees the tree after the same-cycle access update (combinational forward).
- CACHE_PLRU_BYPASS_EN undefined: on a same-set collision, the lookup sees the pre-update state. The update still commits normally.

## Structure

- Shared package cache_pkg holds:
  - PLRU_BITS = WAYS-1
  - set-index width helper
  - typedef for the per-set PLRU vector
- Sub-module cache_plru_tree is purely combinational:
  - inputs: one set's PLRU vector and the valid bits
  - outputs: the one-hot victim way
  - it also computes the next vector for a given one-hot access
- The top level instantiates cache_plru_tree twice, once for the lookup path and once for the update path. The top level also holds the state array, the bypass mux and the output register.

## Test plan

All scenarios use WAYS=4, SETS=64.
- Reset, then lookup set 5 with valid=1111 -> next cycle victim_vld_o=1, victim_oh_o=0001.
- Access set 5 way 0001, then lookup set 5 with valid=1111 -> victim_oh_o=0100.
- Accesses to set 7 with ways 0001, 0100, 0010 on consecutive cycles, then lookup with valid=1111 -> victim_oh_o=1000. Lookup of set 8 -> 0001 (isolation).
- Lookup with valid=1011 in any state -> victim_oh_o=0100. Access with way_oh=0000 -> subsequent victim unchanged.
- After reset, same-cycle access (set 3, 0001) and lookup (set 3, valid=1111) -> 0100 with CACHE_PLRU_BYPASS_EN, 0001 without. The following lookup -> 0100 in both builds.
- Access several sets, then assert rst_i together with lookup_vld_i -> next cycle victim_vld_o=0. Subsequent lookups of those sets -> 0001.
